mem_arbiter: RTL and testbench

- Two-requester arbiter and sequencer in front of the single memory_interface port of the RISC-V core.
- Shares that port between the instruction-fetch path (word reads only) and the load/store path (reads and writes of byte, half or word).
- Runs one transaction at a time, holding each until memory signals completion, and returns the read data to the winning requester.
- Data wins contention. A burst counter prevents fetch starvation, and a timeout counter stops a dead memory from hanging the core.

---
 rtl/mem_arbiter.sv | 92 +++++++++
 tb/tb_mem_arbiter.sv | 129 ++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch (i_*) and load/store (d_*), driving mem_* and returning ack/rdata/err
module mem_arbiter #(
  parameter int D_BURST_MAX = 4,
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [2:0]  d_size,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_size,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        owner
);
  localparam int BW = $clog2(D_BURST_MAX + 1);
  localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  localparam logic [BW-1:0] B_MAX = BW'(D_BURST_MAX);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t state, state_nx;
  logic [BW-1:0] burst;
  logic [TW-1:0] tcnt;
  logic grant_d, expire, done;
  always_comb begin
    grant_d = d_req & (~i_req | burst != B_MAX);
    expire = TIMEOUT != 0 && tcnt == T_LAST;
    done = mem_ready | expire;
    state_nx = state == IDLE ? ((i_req | d_req) ? BUSY : IDLE) :
               state == BUSY ? (done ? RESP : BUSY) : IDLE;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      burst <= '0;
      tcnt <= '0;
      owner <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_size <= '0;
      mem_read <= 1'b0;
      mem_write <= 1'b0;
      i_rdata <= '0;
      d_rdata <= '0;
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      err <= 1'b0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      err <= 1'b0;
      if (state == IDLE && (i_req | d_req)) begin
        owner <= grant_d;
        mem_addr <= grant_d ? d_addr : i_addr;
        mem_wdata <= grant_d ? d_wdata : '0;
        mem_size <= grant_d ? d_size : 3'b010;
        mem_read <= ~grant_d | ~d_we;
        mem_write <= grant_d & d_we;
        // a data grant only counts toward the burst while fetch is waiting
        burst <= (grant_d & i_req) ? (burst == B_MAX ? burst : burst + 1'b1) : '0;
      end
      if (state == BUSY) begin
        if (done) begin
          // mem_ready takes priority over a coincident timeout
          mem_read <= 1'b0;
          mem_write <= 1'b0;
          tcnt <= '0;
          if (owner) d_rdata <= mem_ready ? mem_rdata : '0;
          else i_rdata <= mem_ready ? mem_rdata : '0;
          i_ack <= ~owner;
          d_ack <= owner;
          err <= ~mem_ready;
        end else tcnt <= tcnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vectors, reset abort sequence and randomized transactions against a transaction-level model
module tb_mem_arbiter;
  localparam int D_BURST_MAX = 4;
  localparam int TIMEOUT = 16;
  logic clk = 1'b0, reset = 1'b0;
  logic i_req = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_ready = 1'b0;
  logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
  logic [2:0] d_size = '0;
  logic i_ack, d_ack, err, mem_read, mem_write, owner;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
  logic [2:0] mem_size;
  int checks = 0, errors = 0, txn_id = 0;
  typedef struct {
    logic ir; logic [31:0] ia;
    logic dr; logic dwe; logic [31:0] da; logic [31:0] dwd; logic [2:0] ds;
    int delay; logic [31:0] rd;
    logic eo; int ebusy; logic eerr; logic [31:0] erdata;
  } vec_t;
  vec_t tbl[$];
  mem_arbiter #(.D_BURST_MAX(D_BURST_MAX), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_size(d_size),
    .d_ack(d_ack), .d_rdata(d_rdata), .err(err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_size(mem_size),
    .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .owner(owner)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL txn %0d %s: got %h expected %h", txn_id, name, got, exp);
    end
  endtask
  task automatic run_txn(input vec_t v);
    int busy = 0;
    bit got = 0;
    i_req = v.ir; i_addr = v.ia;
    d_req = v.dr; d_we = v.dwe; d_addr = v.da; d_wdata = v.dwd; d_size = v.ds;
    for (int c = 0; c < 64 && !got; c++) begin
      @(negedge clk);
      if (i_ack | d_ack) begin
        got = 1;
        chk("ack_i", {31'd0, i_ack}, {31'd0, ~v.eo});
        chk("ack_d", {31'd0, d_ack}, {31'd0, v.eo});
        chk("owner_at_ack", {31'd0, owner}, {31'd0, v.eo});
        chk("rdata", v.eo ? d_rdata : i_rdata, v.erdata);
        chk("err", {31'd0, err}, {31'd0, v.eerr});
        chk("busy_cycles", busy, v.ebusy);
        chk("mem_rw_in_resp", {30'd0, mem_read, mem_write}, 32'd0);
      end else if (mem_read | mem_write) begin
        busy++;
        if (busy == 1) begin
          chk("owner", {31'd0, owner}, {31'd0, v.eo});
          chk("mem_addr", mem_addr, v.eo ? v.da : v.ia);
          chk("mem_wdata", mem_wdata, v.eo ? v.dwd : 32'd0);
          chk("mem_size", {29'd0, mem_size}, {29'd0, v.eo ? v.ds : 3'b010});
          chk("mem_read", {31'd0, mem_read}, {31'd0, ~v.eo | ~v.dwe});
          chk("mem_write", {31'd0, mem_write}, {31'd0, v.eo & v.dwe});
          i_addr = ~v.ia; d_addr = ~v.da; d_wdata = ~v.dwd;
        end
        mem_ready = busy == v.delay;
        mem_rdata = mem_ready ? v.rd : $urandom;
      end
    end
    mem_ready = 1'b0; i_req = 1'b0; d_req = 1'b0;
    if (!got) begin
      errors++;
      $display("FAIL txn %0d ack_wait: got no ack expected ack within 64 cycles", txn_id);
    end
    txn_id++;
  endtask
  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ctl"}, {26'd0, i_ack, d_ack, err, mem_read, mem_write, owner}, 32'd0);
    chk({tag, "_addr"}, mem_addr, 32'd0);
    chk({tag, "_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_size"}, {29'd0, mem_size}, 32'd0);
    chk({tag, "_rdata"}, i_rdata | d_rdata, 32'd0);
  endtask
  initial begin
    int burst = 0;
    vec_t v;
    tbl.push_back('{1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 1, 32'h13, 1'b0, 1, 1'b0, 32'h13});
    tbl.push_back('{1'b0, 32'h0, 1'b1, 1'b1, 32'h4, 32'hEE, 3'b000, 2, 32'hABCD, 1'b1, 2, 1'b0, 32'hABCD});
    tbl.push_back('{1'b0, 32'h0, 1'b1, 1'b0, 32'h8, 32'h0, 3'b010, 0, 32'h55, 1'b1, 16, 1'b1, 32'h0});
    tbl.push_back('{1'b0, 32'h0, 1'b1, 1'b0, 32'h8, 32'h0, 3'b010, 3, 32'h1234, 1'b1, 3, 1'b0, 32'h1234});
    tbl.push_back('{1'b1, 32'h200, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 16, 32'hFFFFFFDD, 1'b0, 16, 1'b0, 32'hFFFFFFDD});
    tbl.push_back('{1'b0, 32'h0, 1'b1, 1'b0, 32'hC, 32'h0, 3'b100, 17, 32'h77, 1'b1, 16, 1'b1, 32'h0});
    for (int k = 0; k < 10; k++)
      tbl.push_back('{1'b1, 32'h40 + 32'(k * 4), 1'b1, 1'((k % 2) == 1), 32'h1000 + 32'(k * 4),
                      32'(k), 3'b001, 1, 32'hC0DE0000 + 32'(k), 1'((k % 5) != 4), 1, 1'b0,
                      32'hC0DE0000 + 32'(k)});
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    reset = 1'b1;
    foreach (tbl[n]) run_txn(tbl[n]);
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; d_size = 3'b010;
    @(negedge clk);
    chk("abort_busy", {30'd0, mem_read, owner}, 32'd3);
    #2 reset = 1'b0;
    #1 chk_reset_outputs("abort");
    @(negedge clk);
    reset = 1'b1;
    run_txn('{1'b0, 32'h0, 1'b1, 1'b0, 32'h300, 32'h0, 3'b010, 1, 32'h5A5A, 1'b1, 1, 1'b0, 32'h5A5A});
    for (int n = 0; n < 80; n++) begin
      int sel = $urandom_range(2, 0);
      int sz = $urandom_range(4, 0);
      logic [2:0] szv [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      bit ready_ok;
      v.ir = sel != 1; v.dr = sel != 0;
      v.ia = $urandom; v.da = $urandom; v.dwd = $urandom; v.dwe = 1'($urandom);
      v.ds = szv[sz];
      v.delay = $urandom_range(TIMEOUT + 2, 0);
      v.rd = $urandom;
      v.eo = v.ir && v.dr ? burst < D_BURST_MAX : v.dr;
      burst = (v.eo && v.ir) ? (burst < D_BURST_MAX ? burst + 1 : burst) : 0;
      ready_ok = v.delay >= 1 && v.delay <= TIMEOUT;
      v.ebusy = ready_ok ? v.delay : TIMEOUT;
      v.eerr = !ready_ok;
      v.erdata = ready_ok ? v.rd : 32'd0;
      run_txn(v);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
